seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Scan controller for the 4-digit multiplexed 7-segment display of the clock. It generates the digit-slot timing, holds the displayed digits in a frame-atomic shadow register loaded through a valid/ready handshake, and drives active-low digit enables, the current BCD nibble and the decimal point for the segment decoder. It adds an anti-ghosting dead time, per-digit blink and leading-zero blanking.

## Interface

- DIV, 50000: clock cycles per digit slot; legal when DIV >= 2.
- BLANK, 2: dead-time cycles at the start of each slot, with all digits off; legal when 0 <= BLANK < DIV.
- BLINK_FRAMES, 125: frames per blink half-period; legal when >= 1.

- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- enable  in  1  0 forces all digits off; counters keep running
- upd_valid  in  1  new frame data offered
- upd_ready  out  1  pending buffer empty, so a transfer is accepted
- upd_digits  in  16  BCD digits; digit k in [4k+3:4k]; digit 0 is rightmost
- upd_dp  in  4  decimal points; bit k belongs to digit k
- blink_mask  in  4  bit k set makes digit k blink; sampled live, not shadowed
- lz_en  in  1  leading-zero suppression on digits 3 and 2; sampled live
- sel  out  4  active-low digit enables (1110 = digit 0, 1101 = digit 1, 1011 = digit 2, 0111 = digit 3, 1111 = none)
- seg_bcd  out  4  nibble of the current slot's digit
- seg_dp  out  1  decimal point of the current slot; forced 0 when the digit is blanked
- digit_idx  out  2  current slot index
- frame_start  out  1  one-cycle pulse on the first cycle of slot 0

## Operation

- Prescaler cnt counts 0..DIV-1. When cnt = DIV-1, cnt goes to 0 and idx increments, wrapping 3 -> 0. This wrap is the frame boundary.
- Frame counter fcnt counts frame boundaries 0..BLINK_FRAMES-1. At its wrap, blink phase bphase toggles.
- Active register (act_digits, act_dp) feeds the display. Pending register (pend_digits, pend_dp, pend_full) buffers updates.
- Handshake:
  - upd_ready = ~pend_full, and is 0 while rst is high.
  - A transfer occurs on an edge where upd_valid & upd_ready. It loads the pending register and sets pend_full.
  - upd_digits and upd_dp must be held stable while upd_valid is high and upd_ready is low.
- Commit: on the frame-boundary edge, if pend_full, then act <= pend and pend_full <= 0.
- Transfer on the same edge as the frame boundary with pend_full=0: the data goes to pending and commits at the next boundary. Active never changes mid-frame.
- Blank condition for the current slot is any of:
  - cnt < BLANK
  - enable = 0
  - blink_mask[idx] & bphase
  - lz_en & idx=3 & act digit3=0
  - lz_en & idx=2 & act digit3=0 & act digit2=0
- Digits 1 and 0 are never zero-suppressed.
- Output register:
  - sel <= blank ? 1111 : ~(1 << idx)
  - seg_bcd <= act nibble[idx]; it is driven even when blanked.
  - seg_dp <= act_dp[idx] & ~blank
  - digit_idx <= idx
  - frame_start <= (idx=0 & cnt=0)
- At most one bit of sel is 0 at any time.

## Timing

- Reset values: cnt=0, idx=0, fcnt=0, bphase=0, act=0, pend_full=0. Outputs: sel=1111, seg_bcd=0, seg_dp=0, digit_idx=0, frame_start=0, upd_ready=0.
- Outputs are registered and lag the internal counters by exactly 1 clock. The first edge after rst falls presents slot 0, cnt=0.
- Slot period is DIV cycles and frame period is 4·DIV cycles. The blink period is 2·BLINK_FRAMES frames.
- Commit latency from an accepted transfer to the new value on seg_bcd is at most 4·DIV+1 cycles.
- After pend_full clears at a boundary, upd_ready returns to 1 on the next cycle.
- rst asserted mid-frame: on the next edge everything returns to reset values. Pending data is discarded, and there is no partial commit.
- enable toggling has no effect on the counters or the handshake.

## Test plan

- Basic scan: DIV=4, BLANK=1, enable=1, act=0x1234. Required: sel per 4-cycle slot is 1111,1110,1110,1110 then 1111,1101,1101,1101, and so on. seg_bcd shows 4,3,2,1 for digits 0..3. frame_start pulses every 16 cycles.
- Atomic update: offer 0x5678 mid-slot 1. Required: the transfer is accepted on that edge, then upd_ready=0. seg_bcd keeps the old digits until the frame boundary, then shows 8,7,6,5 with no mixed frame. upd_ready=1 one cycle after the commit.
- Back-pressure: offer 0xAAAA then 0xBBBB back-to-back within one frame. Required: the second offer stalls with upd_ready=0 until the boundary. 0xAAAA displays for one full frame, then 0xBBBB.
- Blink and leading-zero: BLINK_FRAMES=2, blink_mask=0001, lz_en=1, act=0x0045. Required: digits 3 and 2 are never enabled. Digit 0 is enabled for 2 frames, then off for 2 frames. Digit 1 stays steady.
- Reset mid-operation: assert rst during slot 2 while pend_full=1. Required: the next edge gives sel=1111, upd_ready=0, act=0. After release, scan restarts at slot 0 and the old pending data never appears.
- Enable off: enable=0 for 10 cycles. Required: sel=1111 and seg_dp=0 throughout. frame_start keeps its 4·DIV cadence.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scan controller for a 4-digit multiplexed 7-segment display.
// Generates digit-slot timing with an anti-ghosting dead time. Displayed digits
// come from a frame-atomic active register, fed through a one-deep pending
// buffer. Also handles per-digit blink and leading-zero blanking on digits 3/2.
module seg_scan_ctrl #(
    parameter int DIV          = 50000,
    parameter int BLANK        = 2,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] upd_digits,
    input  logic [3:0]  upd_dp,
    input  logic [3:0]  blink_mask,
    input  logic        lz_en,
    output logic [3:0]  sel,
    output logic [3:0]  seg_bcd,
    output logic        seg_dp,
    output logic [1:0]  digit_idx,
    output logic        frame_start
);

    localparam int CW = $clog2(DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [FW-1:0] fcnt;
    logic          bphase;

    logic [15:0]   act_digits;
    logic [3:0]    act_dp;
    logic [15:0]   pend_digits;
    logic [3:0]    pend_dp;
    logic          pend_full;

    logic          slot_end;
    logic          frame_end;
    logic          xfer;
    logic          in_dead;
    logic          blank;
    logic [3:0]    cur_nib;

    // Update handshake: upd_ready is high exactly when the pending buffer is
    // empty and reset is not asserted. A transfer happens on any clock edge
    // where upd_valid && upd_ready. While upd_valid is high and upd_ready is
    // low, the producer holds upd_digits/upd_dp stable. Accepted data becomes
    // visible only at the next frame boundary, so a frame is never mixed.
    assign upd_ready = ~pend_full & ~rst;
    assign xfer      = upd_valid & upd_ready;

    assign slot_end  = (cnt == CW'(DIV - 1));
    assign frame_end = slot_end & (idx == 2'd3);

    // Dead time at the start of each slot; absent entirely when BLANK is 0.
    generate
        if (BLANK > 0) begin : g_dead
            assign in_dead = (cnt < CW'(BLANK));
        end else begin : g_no_dead
            assign in_dead = 1'b0;
        end
    endgenerate

    // Current digit nibble and the combined blanking decision for this slot.
    always_comb begin
        cur_nib = act_digits[{idx, 2'b00} +: 4];
        blank   = in_dead
                | ~enable
                | (blink_mask[idx] & bphase)
                | (lz_en & (idx == 2'd3) & (act_digits[15:12] == 4'd0))
                | (lz_en & (idx == 2'd2) & (act_digits[15:8] == 8'd0));
    end

    // Slot prescaler, digit index, frame counter and blink phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            idx    <= '0;
            fcnt   <= '0;
            bphase <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (frame_end) begin
                if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                    fcnt   <= '0;
                    bphase <= ~bphase;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end
        end
    end

    // Pending buffer load and commit into the active register at frame boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_digits  <= '0;
            act_dp      <= '0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_full   <= 1'b0;
        end else begin
            if (frame_end && pend_full) begin
                act_digits <= pend_digits;
                act_dp     <= pend_dp;
            end
            // xfer implies pend_full is 0, so it never coincides with a commit.
            if (xfer) begin
                pend_digits <= upd_digits;
                pend_dp     <= upd_dp;
                pend_full   <= 1'b1;
            end else if (frame_end) begin
                pend_full <= 1'b0;
            end
        end
    end

    // Registered display outputs, one clock behind the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel         <= 4'b1111;
            seg_bcd     <= 4'd0;
            seg_dp      <= 1'b0;
            digit_idx   <= 2'd0;
            frame_start <= 1'b0;
        end else begin
            sel         <= blank ? 4'b1111 : ~(4'b0001 << idx);
            seg_bcd     <= cur_nib;
            seg_dp      <= act_dp[idx] & ~blank;
            digit_idx   <= idx;
            frame_start <= (idx == 2'd0) && (cnt == '0);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: reset/scan vector table, directed sequences for
// handshake, blink, leading-zero, reset and enable corners, then random traffic
// checked against a reference model computed from the absolute cycle position.
module tb_seg_scan_ctrl;

  localparam int DIV          = 4;
  localparam int BLANK        = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = 4 * DIV;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_digits;
  logic [3:0]  upd_dp;
  logic [3:0]  blink_mask;
  logic        lz_en;
  logic [3:0]  sel;
  logic [3:0]  seg_bcd;
  logic        seg_dp;
  logic [1:0]  digit_idx;
  logic        frame_start;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIV(DIV),
    .BLANK(BLANK),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .upd_digits(upd_digits),
    .upd_dp(upd_dp),
    .blink_mask(blink_mask),
    .lz_en(lz_en),
    .sel(sel),
    .seg_bcd(seg_bcd),
    .seg_dp(seg_dp),
    .digit_idx(digit_idx),
    .frame_start(frame_start)
  );

  // ---------------- counters ----------------
  int n_vec  = 0;
  int n_miss = 0;

  // ---------------- reference model ----------------
  // m_t: cycles presented since reset release; everything else derives from it.
  int          m_t;
  logic [15:0] m_act_d;
  logic [3:0]  m_act_dp;
  logic [15:0] m_pend_d;
  logic [3:0]  m_pend_dp;
  bit          m_pend_full;
  bit          m_xfer;
  // expected {sel, bcd, dp, idx, frame_start}
  logic [11:0] exp_q[$];

  typedef struct {
    logic       en;
    logic [3:0] sel;
    logic       fs;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_edge();
    int   c;
    int   s;
    int   f;
    bit   bph;
    bit   blank;
    bit   accept;
    logic [3:0] e_sel;
    logic [3:0] e_bcd;
    logic       e_dp;
    if (rst) begin
      m_t         = 0;
      m_act_d     = '0;
      m_act_dp    = '0;
      m_pend_full = 0;
      m_xfer      = 0;
      exp_q.push_back({4'hf, 4'h0, 1'b0, 2'd0, 1'b0});
    end else begin
      c     = m_t % DIV;
      s     = (m_t / DIV) % 4;
      f     = m_t / FRAME;
      bph   = ((f / BLINK_FRAMES) % 2) == 1;
      blank = (c < BLANK) || !enable || (blink_mask[s] && bph)
            || (lz_en && s == 3 && m_act_d[15:12] == 4'd0)
            || (lz_en && s == 2 && m_act_d[15:8] == 8'd0);
      e_sel = blank ? 4'hf : ~(4'b0001 << s);
      e_bcd = 4'(m_act_d >> (4 * s));
      e_dp  = m_act_dp[s] && !blank;
      exp_q.push_back({e_sel, e_bcd, e_dp, 2'(s), (m_t % FRAME) == 0});
      accept = upd_valid && !m_pend_full;
      if ((m_t % FRAME) == FRAME - 1 && m_pend_full) begin
        m_act_d     = m_pend_d;
        m_act_dp    = m_pend_dp;
        m_pend_full = 0;
      end
      if (accept) begin
        m_pend_d    = upd_digits;
        m_pend_dp   = upd_dp;
        m_pend_full = 1;
      end
      m_xfer = accept;
      m_t++;
    end
  endtask

  task automatic check_outputs();
    logic [11:0] e;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 16'd1, 16'd0);
    end else begin
      e = exp_q.pop_front();
      chk("sel", 16'(sel), 16'(e[11:8]));
      chk("seg_bcd", 16'(seg_bcd), 16'(e[7:4]));
      chk("seg_dp", 16'(seg_dp), 16'(e[3]));
      chk("digit_idx", 16'(digit_idx), 16'(e[2:1]));
      chk("frame_start", 16'(frame_start), 16'(e[0]));
    end
    chk("upd_ready", 16'(upd_ready), 16'(!m_pend_full && !rst));
    chk("sel_onehot", 16'($countones(~sel) <= 1), 16'd1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_pos(input int pos);
    int n = 0;
    while ((m_t % FRAME) != pos && n < 4 * FRAME) begin
      tick();
      n++;
    end
    chk("wait_pos", 16'(m_t % FRAME), 16'(pos));
  endtask

  task automatic offer(input logic [15:0] d, input logic [3:0] dp);
    int n = 0;
    upd_valid  = 1'b1;
    upd_digits = d;
    upd_dp     = dp;
    tick();
    while (!m_xfer && n < 4 * FRAME) begin
      tick();
      n++;
    end
    chk("offer_accept", 16'(m_xfer), 16'd1);
    upd_valid = 1'b0;
  endtask

  task automatic wait_commit();
    int n = 0;
    while (m_pend_full && n < 4 * FRAME) begin
      tick();
      n++;
    end
    chk("commit_ready", 16'(upd_ready), 16'd1);
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] d;
    for (int k = 0; k < 4; k++)
      d[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
    return d;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] scan_exp [4];

    tbl = '{
      '{1'b1, 4'hf, 1'b1}, '{1'b1, 4'he, 1'b0}, '{1'b1, 4'he, 1'b0}, '{1'b1, 4'he, 1'b0},
      '{1'b1, 4'hf, 1'b0}, '{1'b1, 4'hd, 1'b0}, '{1'b0, 4'hf, 1'b0}, '{1'b0, 4'hf, 1'b0},
      '{1'b1, 4'hf, 1'b0}, '{1'b1, 4'hb, 1'b0}, '{1'b1, 4'hb, 1'b0}, '{1'b1, 4'hb, 1'b0},
      '{1'b1, 4'hf, 1'b0}, '{1'b1, 4'h7, 1'b0}, '{1'b1, 4'h7, 1'b0}, '{1'b1, 4'h7, 1'b0}
    };
    scan_exp = '{4'd4, 4'd3, 4'd2, 4'd1};

    rst        = 1'b1;
    enable     = 1'b1;
    upd_valid  = 1'b0;
    upd_digits = '0;
    upd_dp     = '0;
    blink_mask = '0;
    lz_en      = 1'b0;
    m_t        = 0;
    m_pend_full = 0;
    m_xfer     = 0;
    m_act_d    = '0;
    m_act_dp   = '0;

    // Reset state
    for (int i = 0; i < 3; i++) tick();
    chk("rst_sel", 16'(sel), 16'hf);
    chk("rst_ready", 16'(upd_ready), 16'd0);
    rst = 1'b0;

    // First frame after reset, active = 0
    for (int i = 0; i < 16; i++) begin
      enable = tbl[i].en;
      tick();
      chk("tbl_sel", 16'(sel), 16'(tbl[i].sel));
      chk("tbl_fs", 16'(frame_start), 16'(tbl[i].fs));
      chk("tbl_bcd", 16'(seg_bcd), 16'd0);
    end
    enable = 1'b1;

    // Basic scan with 0x1234
    offer(16'h1234, 4'b0010);
    wait_commit();
    for (int i = 0; i < FRAME; i++) begin
      tick();
      chk("scan_bcd", 16'(seg_bcd), 16'(scan_exp[i / DIV]));
    end

    // Atomic update offered mid-slot 1
    wait_pos(5);
    offer(16'h5678, 4'b0000);
    chk("atomic_ready_low", 16'(upd_ready), 16'd0);
    chk("atomic_old_digit", 16'(seg_bcd), 16'd3);
    wait_commit();
    tick();
    chk("atomic_new_d0", 16'(seg_bcd), 16'd8);

    // Back-pressure: second offer stalls until the boundary
    offer(16'hAAAA, 4'b0000);
    chk("bp_ready_low", 16'(upd_ready), 16'd0);
    offer(16'hBBBB, 4'b0000);
    wait_commit();

    // Blink digit 0 with leading-zero suppression on 0x0045
    offer(16'h0045, 4'b0000);
    wait_commit();
    blink_mask = 4'b0001;
    lz_en      = 1'b1;
    for (int i = 0; i < 8 * FRAME; i++) begin
      tick();
      chk("lz_hidden", 16'(sel == 4'h7 || sel == 4'hb), 16'd0);
    end
    blink_mask = 4'b0000;
    lz_en      = 1'b0;

    // Reset during slot 2 with a pending update
    wait_pos(2);
    offer(16'h9999, 4'hf);
    wait_pos(9);
    rst = 1'b1;
    tick();
    chk("midrst_sel", 16'(sel), 16'hf);
    chk("midrst_ready", 16'(upd_ready), 16'd0);
    chk("midrst_bcd", 16'(seg_bcd), 16'd0);
    rst = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      chk("no_stale", 16'(seg_bcd), 16'd0);
    end

    // Enable off for 10 cycles with decimal points set
    offer(16'h4321, 4'hf);
    wait_commit();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("en_off_sel", 16'(sel), 16'hf);
      chk("en_off_dp", 16'(seg_dp), 16'd0);
    end
    enable = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      if (!upd_valid || m_xfer) begin
        upd_valid  = ($urandom_range(0, 3) == 0);
        upd_digits = rand_digits();
        upd_dp     = 4'($urandom_range(0, 15));
      end
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) blink_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) lz_en = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
